// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: request/acknowledge bus between the two requesters and the RAM arbiter
// Port A (instruction fetch, read-only): a_req, a_addr in; a_rdata, a_ack out.
// Port B (data access, read/write): b_req, b_we, b_addr, b_wdata in; b_rdata, b_ack out.
// master = requester side, slave = arbiter side.
interface ram_access_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_ack;
    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_ack;
    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        input  a_rdata, a_ack, b_rdata, b_ack
    );
    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        output a_rdata, a_ack, b_rdata, b_ack
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin sharing of one async-read, load-strobe-write RAM between two ports
// clk, rst        : clock, synchronous active-high reset
// bus             : port A / port B request-acknowledge bus (slave side)
// busy            : high whenever a RAM access is in progress
// ram_address     : registered RAM word address
// ram_data_in     : registered RAM write data
// ram_load        : registered write strobe, RAM writes on its rising edge
// ram_data_out    : RAM asynchronous read data
module ram_access_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_access_arbiter_if.slave   bus,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_load,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);
    typedef enum logic [1:0] {IDLE, READ, WR_SETUP, WR_STROBE} state_t;
    state_t state, state_n;
    logic last_b, sel_b, grant_a, grant_b, elig_a, elig_b;
    // A port whose ack is high this cycle is not eligible, so a held request is not granted twice.
    always_comb begin
        elig_a  = state == IDLE && bus.a_req && !bus.a_ack;
        elig_b  = state == IDLE && bus.b_req && !bus.b_ack;
        grant_a = elig_a && (!elig_b || last_b);
        grant_b = elig_b && !grant_a;
        state_n = state == IDLE ? (grant_a ? READ : grant_b ? (bus.b_we ? WR_SETUP : READ) : IDLE) :
                  state == WR_SETUP ? WR_STROBE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            sel_b       <= 1'b0;
            bus.a_ack   <= 1'b0;
            bus.b_ack   <= 1'b0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_load    <= 1'b0;
        end else begin
            state     <= state_n;
            bus.a_ack <= state == READ && !sel_b;
            bus.b_ack <= (state == READ && sel_b) || state == WR_STROBE;
            // Strobe rises one cycle after address/data settle and falls after exactly one cycle.
            ram_load  <= state == WR_SETUP;
            if (state == READ && !sel_b) bus.a_rdata <= ram_data_out;
            if (state == READ && sel_b) bus.b_rdata <= ram_data_out;
            if (grant_a || grant_b) begin
                ram_address <= grant_a ? bus.a_addr : bus.b_addr;
                sel_b       <= grant_b;
                last_b      <= grant_b;
            end
            if (grant_b && bus.b_we) ram_data_in <= bus.b_wdata;
        end
    end
    assign busy = state != IDLE;
endmodule
